gomoku_board_ctrl: RTL
======================

GOMOKU_BOARD_CTRL -- requirements
Module: gomoku_board_ctrl

Interface
REQ-001 The parameters SHALL be as follows.
- N, default 16: board side length; legal range 5..16.
- CELL_W, default 2: bits per cell.
- WIN_LEN, default 5: stones in a line needed to win.
- CW: derived parameter equal to $clog2(N).
REQ-002 The ports SHALL be as follows (name, direction, width, meaning).
- Clck, in, 1: the single clock; all state is updated on its rising edge.
- Reset, in, 1: synchronous, active-high reset.
- move_valid, in, 1: a move request is presented.
- move_x, in, CW: column of the requested move.
- move_y, in, CW: row of the requested move.
- move_ready, out, 1: the block can accept a move.
- move_reject, out, 1: one-cycle pulse; the move was refused.
- move_done, out, 1: one-cycle pulse; the accepted move has been fully evaluated.
- board, out, N*N*CELL_W: flat board image.
- current_player, out, 1: side to move; 0 = player 1, 1 = player 2.
- gaming_status, out, 2: game state, encoded per REQ-005.

Function
REQ-003 Cell (x,y) SHALL occupy board bits [(x + y*N)*CELL_W +: CELL_W].
REQ-004 Cell encoding SHALL be: empty = all ones (2'b11), player 1 = 2'b01, player 2 = 2'b10.
REQ-005 gaming_status SHALL be: 00 = playing, 01 = player 1 won, 10 = player 2 won, 11 = draw.
REQ-006 The FSM SHALL have three states: IDLE, CHECK and OVER.
REQ-007 move_ready SHALL be 1 only while the FSM is in IDLE.
REQ-008 A move SHALL be accepted on the cycle where move_valid and move_ready are both 1.
REQ-009 A move whose coordinate is >= N or whose target cell is not empty SHALL be refused:
- move_reject = 1 on the next cycle;
- the FSM stays in IDLE;
- board and current_player are unchanged.
REQ-010 On acceptance at cycle T, at T+1 the target cell SHALL hold the current player's code and the FSM SHALL be in CHECK.
REQ-011 CHECK SHALL scan four directions, (1,0), (0,1), (1,1) and (1,-1):
- each direction is scanned forward and then backward from the placed stone;
- exactly one neighbour cell is examined per cycle;
- a phase ends on an out-of-bounds coordinate, a cell not owned by the mover, or after WIN_LEN-1 steps.
REQ-012 Bounds SHALL be tested on the signed coordinate; a run SHALL never wrap across a row or column edge.
REQ-013 For each direction, the run length SHALL be 1 plus the forward count plus the backward count; a run of length >= WIN_LEN is a win, and scanning SHALL stop at once.
REQ-014 Worst-case CHECK duration SHALL be 8*(WIN_LEN-1) cycles; the last CHECK cycle asserts move_done.
REQ-015 The outcome of CHECK SHALL be applied in the cycle after move_done:
- win: gaming_status = 01 or 10 according to the mover, and FSM -> OVER;
- no win and the move counter has reached N*N: gaming_status = 11, and FSM -> OVER;
- otherwise: current_player toggles, and FSM -> IDLE.
REQ-016 OVER SHALL hold board and status with move_ready = 0 until Reset.
REQ-017 move_valid during CHECK or OVER SHALL be ignored, with no reject pulse.
REQ-018 The move counter SHALL be $clog2(N*N+1) bits wide and SHALL count accepted moves only.

Reset
REQ-019 A cycle with Reset = 1 SHALL set every cell to empty, gaming_status = 00, current_player = 0, move counter = 0, FSM = IDLE, and move_reject = move_done = 0.
REQ-020 Reset SHALL take priority over every other event, including a move accepted in the same cycle and a scan in progress in CHECK; no partial result is retained.
REQ-021 move_ready SHALL be 1 in the first cycle after Reset deasserts.

Structure
REQ-022 Package gomoku_pkg SHALL hold:
- the cell codes EMPTY, P1 and P2;
- the status codes;
- the direction-delta table;
- a cell-offset function (x,y,N,CELL_W).
REQ-023 The direction/step counters and the bounds test SHALL live in sub-module gomoku_win_scan, which exposes start, done and win signals; the cell read multiplexer stays in the parent.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- Horizontal win: P1 plays (0,0)..(4,0), interleaved with P2 at (0,1)..(3,1) -> after the 9th move, gaming_status = 01, move_ready = 0, and cell (4,0) = 01.
- Occupied cell: P1 plays (3,3), then P2 plays (3,3) -> move_reject pulses one cycle, current_player stays 1, and the board is unchanged.
- No edge wrap: P1 plays (14,0), (15,0), (0,1), (1,1), (2,1), with P2 on scattered cells -> gaming_status stays 00.
- Anti-diagonal win: P2 plays (4,0), (3,1), (2,2), (1,3), (0,4), with P1 elsewhere -> gaming_status = 10.
- Draw, with N = 5 and WIN_LEN = 6: 25 legal moves -> gaming_status = 11 after the 25th move_done.
- Reset mid-CHECK: Reset is asserted on the 2nd CHECK cycle -> next cycle, board is all ones, status = 00, and move_ready = 1.

Source files
------------

// File: rtl/gomoku_pkg.sv
// Shared definitions for the gomoku board controller.
//   - cell codes (EMPTY / P1 / P2)
//   - game status and controller state encodings
//   - direction delta table used by the win scanner
//   - flat-board cell offset helper
package gomoku_pkg;

  localparam logic [1:0] EMPTY = 2'b11;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_PLAYING = 2'b00,
    ST_P1_WIN  = 2'b01,
    ST_P2_WIN  = 2'b10,
    ST_DRAW    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam int NUM_DIRS = 4;

  // Directions: horizontal, vertical, diagonal, anti-diagonal.
  localparam int DIR_DX [NUM_DIRS] = '{1, 0, 1,  1};
  localparam int DIR_DY [NUM_DIRS] = '{0, 1, 1, -1};

  function automatic int cell_offset(input int x, input int y, input int n, input int cell_w);
    return (x + y * n) * cell_w;
  endfunction

endpackage

// File: rtl/gomoku_win_scan.sv
// Win scanner: walks the four line directions outward from the placed
// stone, forward then backward, probing one neighbour cell per cycle.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   start                  load origin and begin scanning (one-cycle pulse)
//   origin_x, origin_y     coordinate of the stone just placed
//   cell_owned             parent's verdict: probed cell belongs to the mover
//   probe_x, probe_y       coordinate being probed this cycle
//   probe_valid            probe coordinate is on the board
//   done                   this is the final scan cycle
//   win                    a winning run was found (valid with done)
module gomoku_win_scan #(
  parameter int N       = 16,
  parameter int WIN_LEN = 5,
  parameter int CW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] origin_x,
  input  logic [CW-1:0] origin_y,
  input  logic          cell_owned,
  output logic [CW-1:0] probe_x,
  output logic [CW-1:0] probe_y,
  output logic          probe_valid,
  output logic          done,
  output logic          win
);
  import gomoku_pkg::*;

  // Signed width covers origin +/- (WIN_LEN-1) without overflow.
  localparam int SW = $clog2(N + WIN_LEN) + 2;
  localparam int RW = $clog2(WIN_LEN + 1);
  localparam int LW = $clog2(2 * WIN_LEN + 1);

  localparam logic signed [SW-1:0] ZERO_S = '0;
  localparam logic signed [SW-1:0] N_S    = SW'(N);

  logic                 busy;
  logic [1:0]           dir;
  logic                 back;
  logic signed [SW-1:0] org_x, org_y;
  logic signed [SW-1:0] cur_x, cur_y;
  logic [RW-1:0]        remain;
  logic [LW-1:0]        run;

  logic [1:0]           dir_nxt;
  logic signed [SW-1:0] dx, dy, ndx, ndy;
  logic signed [SW-1:0] org_in_x, org_in_y;
  logic                 in_bounds, hit, phase_end, last_phase, win_now;
  logic [LW-1:0]        run_nxt;

  always_comb begin
    dir_nxt    = dir + 2'd1;
    dx         = SW'(DIR_DX[dir]);
    dy         = SW'(DIR_DY[dir]);
    ndx        = SW'(DIR_DX[dir_nxt]);
    ndy        = SW'(DIR_DY[dir_nxt]);
    org_in_x   = $signed(SW'(origin_x));
    org_in_y   = $signed(SW'(origin_y));
    // Bounds on the signed coordinate so a run can never wrap an edge.
    in_bounds  = (cur_x >= ZERO_S) && (cur_x < N_S) &&
                 (cur_y >= ZERO_S) && (cur_y < N_S);
    hit        = busy && in_bounds && cell_owned;
    run_nxt    = run + LW'(hit);
    win_now    = hit && (run_nxt >= LW'(WIN_LEN));
    phase_end  = !hit || (remain == RW'(1));
    last_phase = (dir == 2'd3) && back;
    done       = busy && (win_now || (phase_end && last_phase));
    win        = win_now;
    probe_valid = busy && in_bounds;
    probe_x    = cur_x[CW-1:0];
    probe_y    = cur_y[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      dir    <= 2'd0;
      back   <= 1'b0;
      org_x  <= '0;
      org_y  <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      remain <= '0;
      run    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      dir    <= 2'd0;
      back   <= 1'b0;
      org_x  <= org_in_x;
      org_y  <= org_in_y;
      cur_x  <= org_in_x + SW'(DIR_DX[0]);
      cur_y  <= org_in_y + SW'(DIR_DY[0]);
      remain <= RW'(WIN_LEN - 1);
      run    <= LW'(1);
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else if (phase_end) begin
        remain <= RW'(WIN_LEN - 1);
        if (!back) begin
          // Backward phase keeps the forward count in run.
          back  <= 1'b1;
          cur_x <= org_x - dx;
          cur_y <= org_y - dy;
          run   <= run_nxt;
        end else begin
          back  <= 1'b0;
          dir   <= dir_nxt;
          cur_x <= org_x + ndx;
          cur_y <= org_y + ndy;
          run   <= LW'(1);
        end
      end else begin
        remain <= remain - RW'(1);
        run    <= run_nxt;
        if (back) begin
          cur_x <= cur_x - dx;
          cur_y <= cur_y - dy;
        end else begin
          cur_x <= cur_x + dx;
          cur_y <= cur_y + dy;
        end
      end
    end
  end

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Gomoku board controller: holds the board, validates and places moves,
// runs the win scan and tracks whose turn it is and the game outcome.
// Ports:
//   Clck, Reset            clock and synchronous active-high reset
//   move_valid/x/y         move request and its coordinate
//   move_ready             controller is idle and can take a move
//   move_reject            one-cycle pulse: request refused
//   move_done              one-cycle pulse: last cycle of the win scan
//   board                  flat image, cell (x,y) at [(x+y*N)*CELL_W +: CELL_W]
//   current_player         side to move (0 = player 1, 1 = player 2)
//   gaming_status          00 playing, 01 P1 won, 10 P2 won, 11 draw
//
// state | meaning
// IDLE  | waiting for a move; move_ready = 1
// CHECK | stone placed, win scan running one cell per cycle
// OVER  | game finished, everything frozen until Reset
module gomoku_board_ctrl #(
  parameter int N       = 16,
  parameter int CELL_W  = 2,
  parameter int WIN_LEN = 5,
  parameter int CW      = $clog2(N)
) (
  input  logic                     Clck,
  input  logic                     Reset,
  input  logic                     move_valid,
  input  logic [CW-1:0]            move_x,
  input  logic [CW-1:0]            move_y,
  output logic                     move_ready,
  output logic                     move_reject,
  output logic                     move_done,
  output logic [N*N*CELL_W-1:0]    board,
  output logic                     current_player,
  output logic [1:0]               gaming_status
);
  import gomoku_pkg::*;

  localparam int NC  = N * N;
  localparam int MCW = $clog2(NC + 1);

  localparam logic [CELL_W-1:0] CELL_EMPTY = '1;
  localparam logic [CELL_W-1:0] CELL_P1    = CELL_W'(P1);
  localparam logic [CELL_W-1:0] CELL_P2    = CELL_W'(P2);

  state_e           state;
  status_e          status;
  logic [MCW-1:0]   move_cnt;

  logic [CW-1:0]    probe_x, probe_y;
  logic             probe_valid, scan_done, scan_win, cell_owned;
  logic [31:0]      mx_ext, my_ext;
  logic             coord_ok, target_empty, accept, refuse;
  int               target_off, probe_off;
  logic [CELL_W-1:0] target_cell, probe_cell, mover_code;

  always_comb begin
    mx_ext       = 32'(move_x);
    my_ext       = 32'(move_y);
    coord_ok     = (mx_ext < 32'(N)) && (my_ext < 32'(N));
    target_off   = cell_offset(int'(move_x), int'(move_y), N, CELL_W);
    probe_off    = cell_offset(int'(probe_x), int'(probe_y), N, CELL_W);
    // Out-of-range reads only happen when coord_ok / probe_valid mask them.
    target_cell  = board[target_off +: CELL_W];
    probe_cell   = board[probe_off +: CELL_W];
    target_empty = coord_ok && (target_cell == CELL_EMPTY);
    mover_code   = current_player ? CELL_P2 : CELL_P1;
    cell_owned   = probe_valid && (probe_cell == mover_code);
    accept       = (state == IDLE) && move_valid && target_empty;
    refuse       = (state == IDLE) && move_valid && !target_empty;
  end

  gomoku_win_scan #(
    .N       (N),
    .WIN_LEN (WIN_LEN),
    .CW      (CW)
  ) u_win_scan (
    .clk         (Clck),
    .reset       (Reset),
    .start       (accept),
    .origin_x    (move_x),
    .origin_y    (move_y),
    .cell_owned  (cell_owned),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .probe_valid (probe_valid),
    .done        (scan_done),
    .win         (scan_win)
  );

  assign move_done     = scan_done;
  assign gaming_status = status;

  always_ff @(posedge Clck) begin
    if (Reset) begin
      board          <= '1;
      state          <= IDLE;
      status         <= ST_PLAYING;
      current_player <= 1'b0;
      move_cnt       <= '0;
      move_ready     <= 1'b1;
      move_reject    <= 1'b0;
    end else begin
      move_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            board[target_off +: CELL_W] <= mover_code;
            move_cnt   <= move_cnt + MCW'(1);
            state      <= CHECK;
            move_ready <= 1'b0;
          end else if (refuse) begin
            move_reject <= 1'b1;
          end
        end
        CHECK: begin
          if (scan_done) begin
            if (scan_win) begin
              status <= current_player ? ST_P2_WIN : ST_P1_WIN;
              state  <= OVER;
            end else if (move_cnt == MCW'(NC)) begin
              status <= ST_DRAW;
              state  <= OVER;
            end else begin
              current_player <= ~current_player;
              state          <= IDLE;
              move_ready     <= 1'b1;
            end
          end
        end
        OVER: begin
        end
        default: begin
          state      <= IDLE;
          move_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
